// File: rtl/boid_frame_scheduler.sv
// boid_frame_scheduler
//   Sequences the per-frame refresh of the double-buffered boid display RAM.
//   On a screen_end pulse while idle it swaps front/back buffers, clears the
//   back buffer, then walks every BPU once and writes one pixel per boid.
//   CPU position updates are held off while the BPUs are being sampled.
//
// Build option: define BOID_FAST_CLEAR_EN to replace the per-pixel clear walk
//   with a single-cycle fb_clear pulse (the RAM bulk-resets the back buffer).
//
// Ports
//   clock        system clock
//   resetn       synchronous active-low reset
//   screen_end   1-cycle end-of-visible-frame pulse from the VGA controller
//   boid_sel     index of the BPU whose boid_x/boid_y is being sampled
//   boid_x/y     coordinates of the selected BPU (combinational from BPU mux)
//   fb_we/fb_waddr/fb_wdata  back-buffer write port (1 = boid, 0 = clear)
//   fb_clear     bulk clear pulse (fast-clear build only, otherwise 0)
//   front_sel    buffer scanned out by VGA; back buffer is ~front_sel
//   cpu_upd_req/cpu_upd_gnt  CPU BPU-position write handshake
//   busy         high whenever the sequencer is not idle
//   overrun_cnt  saturating count of screen_end pulses dropped while busy
//
// state   | meaning
// S_IDLE  | waiting for screen_end
// S_SWAP  | toggle front/back buffer, prime the clear
// S_CLEAR | zero the back buffer (one pixel per cycle, or one bulk pulse)
// S_DRAW  | sample BPU boid_sel, register its pixel write for next cycle
// S_FLUSH | emit the last boid's write, return to idle

module boid_frame_scheduler #(
    parameter int NUM_BOIDS = 4,
    parameter int BOID_BITS = 2,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ADDR_W    = 19,
    parameter int OVR_W     = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 screen_end,
    output logic [BOID_BITS-1:0] boid_sel,
    input  logic [9:0]           boid_x,
    input  logic [8:0]           boid_y,
    output logic                 fb_we,
    output logic [ADDR_W-1:0]    fb_waddr,
    output logic                 fb_wdata,
    output logic                 fb_clear,
    output logic                 front_sel,
    input  logic                 cpu_upd_req,
    output logic                 cpu_upd_gnt,
    output logic                 busy,
    output logic [OVR_W-1:0]     overrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWAP,
        S_CLEAR,
        S_DRAW,
        S_FLUSH
    } state_t;

    localparam logic [9:0]           H_LIM     = 10'(H_RES);
    localparam logic [8:0]           V_LIM     = 9'(V_RES);
    localparam logic [ADDR_W-1:0]    H_RES_A   = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [BOID_BITS-1:0] LAST_BOID = BOID_BITS'(NUM_BOIDS - 1);
    localparam logic [OVR_W-1:0]     OVR_MAX   = '1;

    state_t            state;
    logic              draw_ok;
    logic [ADDR_W-1:0] draw_addr;

    always_comb begin
        draw_ok   = (boid_x < H_LIM) && (boid_y < V_LIM);
        draw_addr = ADDR_W'(boid_x) + H_RES_A * ADDR_W'(boid_y);
    end

    // BPU positions must not move while DRAW is sampling them.
    assign cpu_upd_gnt = cpu_upd_req & (state != S_DRAW);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            boid_sel    <= '0;
            fb_we       <= 1'b0;
            fb_waddr    <= '0;
            fb_wdata    <= 1'b0;
            fb_clear    <= 1'b0;
            front_sel   <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            // A frame request that arrives mid-update is dropped, only counted.
            if (screen_end && (state != S_IDLE) && (overrun_cnt != OVR_MAX))
                overrun_cnt <= overrun_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    fb_we <= 1'b0;
                    if (screen_end) begin
                        state     <= S_SWAP;
                        busy      <= 1'b1;
                        front_sel <= ~front_sel;
                    end
                end
                S_SWAP: begin
                    state <= S_CLEAR;
`ifdef BOID_FAST_CLEAR_EN
                    fb_clear <= 1'b1;
                    fb_we    <= 1'b0;
`else
                    fb_we    <= 1'b1;
                    fb_wdata <= 1'b0;
                    fb_waddr <= '0;
`endif
                end
                S_CLEAR: begin
`ifdef BOID_FAST_CLEAR_EN
                    fb_clear <= 1'b0;
                    state    <= S_DRAW;
                    boid_sel <= '0;
`else
                    // fb_waddr doubles as the clear pixel counter.
                    if (fb_waddr == LAST_ADDR) begin
                        fb_we    <= 1'b0;
                        state    <= S_DRAW;
                        boid_sel <= '0;
                    end else begin
                        fb_waddr <= fb_waddr + 1'b1;
                    end
`endif
                end
                S_DRAW: begin
                    // Write for the boid sampled this cycle lands next cycle.
                    fb_we    <= draw_ok;
                    fb_waddr <= draw_addr;
                    fb_wdata <= 1'b1;
                    if (boid_sel == LAST_BOID) begin
                        state    <= S_FLUSH;
                        boid_sel <= '0;
                    end else begin
                        boid_sel <= boid_sel + 1'b1;
                    end
                end
                S_FLUSH: begin
                    fb_we <= 1'b0;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    fb_we <= 1'b0;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boid_frame_scheduler.sv
module tb_boid_frame_scheduler;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int N  = 4;
    localparam int AW = 19;
`ifdef BOID_FAST_CLEAR_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int CLR_LEN   = FAST ? 1 : H * V;
    localparam int FRAME_LEN = 1 + CLR_LEN + N + 1;

    logic          clock;
    logic          resetn;
    logic          screen_end;
    logic [1:0]    boid_sel;
    logic [9:0]    boid_x;
    logic [8:0]    boid_y;
    logic          fb_we;
    logic [AW-1:0] fb_waddr;
    logic          fb_wdata;
    logic          fb_clear;
    logic          front_sel;
    logic          cpu_upd_req;
    logic          cpu_upd_gnt;
    logic          busy;
    logic [7:0]    overrun_cnt;

    logic [9:0] bx_arr [N];
    logic [8:0] by_arr [N];

    assign boid_x = bx_arr[boid_sel];
    assign boid_y = by_arr[boid_sel];

    boid_frame_scheduler #(
        .NUM_BOIDS(N), .BOID_BITS(2), .H_RES(H), .V_RES(V), .ADDR_W(AW), .OVR_W(8)
    ) dut (
        .clock(clock), .resetn(resetn), .screen_end(screen_end),
        .boid_sel(boid_sel), .boid_x(boid_x), .boid_y(boid_y),
        .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_clear(fb_clear),
        .front_sel(front_sel), .cpu_upd_req(cpu_upd_req), .cpu_upd_gnt(cpu_upd_gnt),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame-relative position p: 0 = swap cycle, then CLR_LEN clear cycles,
    // then N sampling cycles, then one flush cycle.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic          data;
        logic [1:0]    sel;
        logic          clr;
        logic          draw;
    } exp_t;

    logic m_busy;
    int   m_p;
    logic m_front;
    int   m_ovr;
    bit   started = 1'b0;

    function automatic exp_t exp_at(input int p);
        exp_t e;
        int k, j;
        e = '0;
        if (p >= 1 && p <= CLR_LEN) begin
            if (FAST) e.clr = 1'b1;
            else begin
                e.we   = 1'b1;
                e.addr = AW'(p - 1);
            end
        end else if (p > CLR_LEN && p <= CLR_LEN + N + 1) begin
            k = p - CLR_LEN - 1;
            if (k < N) begin
                e.sel  = 2'(k);
                e.draw = 1'b1;
            end
            if (k >= 1) begin
                j = k - 1;
                if (int'(bx_arr[j]) < H && int'(by_arr[j]) < V) begin
                    e.we   = 1'b1;
                    e.addr = AW'(int'(bx_arr[j]) + H * int'(by_arr[j]));
                    e.data = 1'b1;
                end
            end
        end
        return e;
    endfunction

    always @(posedge clock) begin
        if (!resetn) begin
            m_busy  <= 1'b0;
            m_p     <= 0;
            m_front <= 1'b0;
            m_ovr   <= 0;
            started <= 1'b1;
        end else if (started) begin
            if (!m_busy) begin
                if (screen_end) begin
                    m_busy  <= 1'b1;
                    m_p     <= 0;
                    m_front <= ~m_front;
                end
            end else begin
                if (screen_end && m_ovr < 255) m_ovr <= m_ovr + 1;
                if (m_p + 1 == FRAME_LEN) m_busy <= 1'b0;
                m_p <= m_p + 1;
            end
        end
    end

    always @(negedge clock) begin : cmp
        exp_t e;
        if (started && resetn) begin
            e = m_busy ? exp_at(m_p) : '0;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("front_sel", 32'(front_sel), 32'(m_front));
            chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
            chk("boid_sel", 32'(boid_sel), 32'(e.sel));
            chk("cpu_upd_gnt", 32'(cpu_upd_gnt), 32'(cpu_upd_req & ~e.draw));
            chk("fb_we", 32'(fb_we), 32'(e.we));
            chk("fb_clear", 32'(fb_clear), 32'(e.clr));
            if (e.we) begin
                chk("fb_waddr", 32'(fb_waddr), 32'(e.addr));
                chk("fb_wdata", 32'(fb_wdata), 32'(e.data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int fr_cycles, fr_clr_w, fr_clr_pulse, gnt_clear, gnt_draw, gnt_flush;
    logic [AW-1:0] draw_q [$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        screen_end = 1'b1;
        tick();
        screen_end = 1'b0;
    endtask

    task automatic set_boid(input int k, input int x, input int y);
        bx_arr[k] = 10'(x);
        by_arr[k] = 9'(y);
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!busy) break;
        end
        if (i == 300) begin
            errors++;
            checks++;
            $display("FAIL %s: busy still high after %0d cycles, required idle", nm, i);
        end
        tick();
    endtask

    task automatic run_frame(input string nm);
        int i;
        draw_q.delete();
        fr_clr_w = 0; fr_clr_pulse = 0; gnt_clear = 0; gnt_draw = 0; gnt_flush = 0;
        pulse();
        for (i = 0; i < 300; i++) begin
            @(negedge clock);
            if (!busy) break;
            if (fb_we && !fb_wdata) fr_clr_w++;
            if (fb_we && fb_wdata) draw_q.push_back(fb_waddr);
            if (fb_clear) fr_clr_pulse++;
            if (i >= 1 && i <= CLR_LEN && cpu_upd_gnt) gnt_clear++;
            if (i > CLR_LEN && i <= CLR_LEN + N && cpu_upd_gnt) gnt_draw++;
            if (i == CLR_LEN + N + 1) gnt_flush = int'(cpu_upd_gnt);
        end
        if (i == 300) begin
            errors++;
            checks++;
            $display("FAIL %s: frame never finished, busy high after %0d cycles", nm, i);
        end
        fr_cycles = i;
        tick();
    endtask

    task automatic chk_draw(input string nm, input int n, input int w0, input int w1,
                            input int w2, input int w3);
        int w [4];
        w = '{w0, w1, w2, w3};
        chk({nm, "_count"}, 32'(draw_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            chk({nm, "_addr"}, (i < draw_q.size()) ? 32'(draw_q[i]) : 32'hFFFF_FFFF, 32'(w[i]));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        resetn = 1'b0; screen_end = 1'b0; cpu_upd_req = 1'b0;
        for (int k = 0; k < N; k++) set_boid(k, 0, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // 1: reset in the middle of a clear
        pulse();
        repeat (5) tick();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_front_sel", 32'(front_sel), 32'd0);
        chk("rst_overrun", 32'(overrun_cnt), 32'd0);
        tick();

        // 2: normal frame
        set_boid(0, 1, 0); set_boid(1, 2, 1); set_boid(2, 7, 3); set_boid(3, 0, 0);
        run_frame("frame");
        chk("frame_front_sel", 32'(front_sel), 32'd1);
        chk("frame_cycles", 32'(fr_cycles), FAST ? 32'd7 : 32'd38);
        chk("frame_clear_writes", 32'(fr_clr_w), FAST ? 32'd0 : 32'd32);
        chk("frame_clear_pulses", 32'(fr_clr_pulse), FAST ? 32'd1 : 32'd0);
        chk_draw("frame_draw", 4, 1, 10, 31, 0);

        // 3: out-of-range boids are skipped
        set_boid(2, 8, 0); set_boid(3, 0, 4);
        run_frame("oor");
        chk("oor_front_sel", 32'(front_sel), 32'd0);
        chk("oor_cycles", 32'(fr_cycles), FAST ? 32'd7 : 32'd38);
        chk_draw("oor_draw", 2, 1, 10, 0, 0);

        // 5: CPU arbitration held across a whole frame
        set_boid(2, 5, 2); set_boid(3, 3, 3);
        cpu_upd_req = 1'b1;
        run_frame("arb");
        cpu_upd_req = 1'b0;
        chk("arb_gnt_clear", 32'(gnt_clear), 32'(CLR_LEN));
        chk("arb_gnt_draw", 32'(gnt_draw), 32'd0);
        chk("arb_gnt_flush", 32'(gnt_flush), 32'd1);
        chk_draw("arb_draw", 4, 1, 10, 21, 27);

        // 4: overrun -- one drop mid-clear, then a continuous stream
        pulse();
        repeat (FAST ? 2 : 10) tick();
        pulse();
        wait_idle("ovr_first");
        chk("ovr_one", 32'(overrun_cnt), 32'd1);
        chk("ovr_front_sel", 32'(front_sel), 32'd0);
        screen_end = 1'b1;
        repeat (400) tick();
        screen_end = 1'b0;
        wait_idle("ovr_stream");
        chk("ovr_saturated", 32'(overrun_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
